// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants for the shift-add multiplier: FSM state encoding and default operand width.
// No logic; imported by the interface, datapath and controller.
package mult_pkg;
    localparam int N_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result bundle between the operand source (master) and the multiplier controller (slave).
// Start is a request with no ready; the source watches busy/done to know when it was taken.
interface shift_add_mult_ctrl_if import mult_pkg::*; #(
    parameter int N = N_DEFAULT
);
    localparam int CW = $clog2(N + 1);

    logic              start;
    logic [N-1:0]      a;
    logic [N-1:0]      b;
    logic              busy;
    logic              done;
    logic [2*N-1:0]    product;
    logic [CW-1:0]     iter;

    modport master (
        output start, a, b,
        input  busy, done, product, iter
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, iter
    );
endinterface

// File: rtl/shift_add_mult_ctrl_datapath.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers and the 2N-bit adder.
// Latency: one add/shift per i_step cycle; i_load captures operands. No backpressure.
// Macro MULT_EARLY_TERM_EN enables the next-multiplier-zero status used for early exit.
module shift_add_datapath import mult_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_mplier_zero,
    output logic [2*N-1:0] o_acc_nxt
);
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_acc;
    logic           w_lsb;

    assign w_lsb     = r_mplier[0];
    assign o_acc_nxt = r_acc + (w_lsb ? r_mcand : '0);

    // Looks at the multiplier as it will be after this cycle's shift.
`ifdef MULT_EARLY_TERM_EN
    assign o_mplier_zero = (r_mplier[N-1:1] == '0);
`else
    assign o_mplier_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (i_step) begin
            r_acc    <= o_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencing controller for an unsigned N x N shift-add multiplier (IDLE/CALC/DONE FSM).
// Latency: N CALC cycles after accepted start, then a one-cycle done pulse (fewer with MULT_EARLY_TERM_EN).
// Start is only taken in IDLE or DONE and ignored while busy; holding it in DONE runs back-to-back.
module shift_add_mult_ctrl import mult_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_mult_ctrl_if.slave bus
);
    localparam int             CW        = $clog2(N + 1);
    localparam logic [CW-1:0]  ITER_LAST = CW'(N - 1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [CW-1:0]  r_iter;
    logic [2*N-1:0] r_product;
    logic [2*N-1:0] w_acc_nxt;
    logic           w_mplier_zero;
    logic           w_accept;
    logic           w_step;
    logic           w_last;

    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_step   = (r_state == ST_CALC);
    assign w_last   = (r_iter == ITER_LAST) || w_mplier_zero;

    shift_add_datapath #(.N(N)) u_datapath (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_accept),
        .i_step        (w_step),
        .i_a           (bus.a),
        .i_b           (bus.b),
        .o_mplier_zero (w_mplier_zero),
        .o_acc_nxt     (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = bus.start ? ST_CALC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            ST_CALC: bus.busy = 1'b1;
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Product captures the adder output on the last step, so it is valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter    <= '0;
            r_product <= '0;
        end else begin
            if (w_accept)    r_iter <= '0;
            else if (w_step) r_iter <= r_iter + CW'(1);
            if (w_step && w_last) r_product <= w_acc_nxt;
        end
    end

    assign bus.product = r_product;
    assign bus.iter    = r_iter;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed self-checking bench for shift_add_mult_ctrl (N=4), vector table plus multi-cycle sequences.
// Expected iteration counts follow MULT_EARLY_TERM_EN when it is defined.
module tb_shift_add_mult_ctrl;
    localparam int N = 4;
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        int         iter_full;
        int         iter_early;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    shift_add_mult_ctrl_if #(.N(N)) bus ();

    shift_add_mult_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick_iter(input int full, input int early);
        return EARLY ? early : full;
    endfunction

    // Waits for the done pulse, counting busy cycles; bounded.
    task automatic wait_done(output int nbusy, output int seen);
        nbusy = 0;
        seen  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
            if (bus.busy === 1'b1) nbusy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_b,
                          input logic [7:0] ep, input int ei);
        int nbusy;
        int seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(nbusy, seen);
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_cycles"}, nbusy, ei);
        chk({tag, "_product"}, int'(bus.product), int'(ep));
        chk({tag, "_iter"}, int'(bus.iter), ei);
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, int'(bus.done), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int nbusy;
        int seen;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{4'd3,  4'd5,  8'd15,  4, 3};
        vecs[1] = '{4'd0,  4'd9,  8'd0,   4, 4};
        vecs[2] = '{4'd9,  4'd0,  8'd0,   4, 1};
        vecs[3] = '{4'd15, 4'd15, 8'd225, 4, 4};
        vecs[4] = '{4'd9,  4'd2,  8'd18,  4, 2};
        vecs[5] = '{4'd1,  4'd1,  8'd1,   4, 1};
        vecs[6] = '{4'd7,  4'd8,  8'd56,  4, 4};
        vecs[7] = '{4'd12, 4'd3,  8'd36,  4, 2};

        // Reset held with start asserted: nothing may move.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 4'd5;
        bus.b     = 4'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_outputs_zero",
                int'({bus.busy, bus.done, bus.product, bus.iter}), 0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_busy", int'(bus.busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod,
                   pick_iter(vecs[i].iter_full, vecs[i].iter_early));
        end

        // Back-to-back: start held through DONE, new operands picked up there.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
        @(posedge clk);
        #1;
        bus.a = 4'd2;
        bus.b = 4'd7;
        wait_done(nbusy, seen);
        chk("b2b_first_done_seen", seen, 1);
        chk("b2b_first_product", int'(bus.product), 225);
        chk("b2b_first_iter", int'(bus.iter), 4);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle_gap_busy", int'(bus.busy), 1);
        wait_done(nbusy, seen);
        chk("b2b_second_done_seen", seen, 1);
        chk("b2b_second_busy_cycles", nbusy + 1, pick_iter(4, 3));
        chk("b2b_second_product", int'(bus.product), 14);
        chk("b2b_second_iter", int'(bus.iter), pick_iter(4, 3));

        // Start pulsed mid-CALC must be ignored.
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd3;
        bus.b     = 4'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(nbusy, seen);
        chk("midcalc_done_seen", seen, 1);
        chk("midcalc_product", int'(bus.product), 15);
        chk("midcalc_iter", int'(bus.iter), pick_iter(4, 3));
        @(negedge clk);
        chk("midcalc_back_to_idle", int'({bus.busy, bus.done}), 0);

        // Reset on the second CALC cycle discards the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd7;
        bus.b     = 4'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_product", int'(bus.product), 0);
        chk("rst_mid_iter", int'(bus.iter), 0);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1;
        end
        chk("rst_mid_no_done", seen, 0);
        run_op("after_rst", 4'd7, 4'd7, 8'd49, pick_iter(4, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
